// File: rtl/rf_scoreboard.sv
//==============================================================================
// Module      : rf_scoreboard
// Description : 2R/1W register file with a per-register busy scoreboard,
//               read-hazard stall and pending-writes counter. Define
//               RF_BYPASS_EN to forward same-cycle writeback data to reads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rR1,
    input  logic [ADDR_W-1:0] rR2,
    input  logic              re1,
    input  logic              re2,
    output logic [DATA_W-1:0] rD1,
    output logic [DATA_W-1:0] rD2,
    output logic              rbusy1,
    output logic              rbusy2,
    output logic              stall,
    input  logic [ADDR_W-1:0] wR,
    input  logic              we,
    input  logic [DATA_W-1:0] wD,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   r_pend_cnt;
    logic [ADDR_W:0]   w_pend_nxt;
    logic              w_wr_ok;
    logic              w_rsv_ok;

    assign w_wr_ok  = we     && !((ZERO_REG != 0) && (wR == '0));
    assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Priority: flush, then writeback release, then reservation.
    always_comb begin
        w_busy_nxt = flush ? '0 : r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wR] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pend_nxt = w_pend_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_data[wR] <= wD;
        end
    end

    logic [1:0][ADDR_W-1:0] w_ra;
    logic [1:0][DATA_W-1:0] w_rd;
    logic [1:0]             w_rb;

    assign w_ra = {rR2, rR1};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rport
            logic w_zero;
            logic w_fwd;

            assign w_zero = (ZERO_REG != 0) && (w_ra[p] == '0);
`ifdef RF_BYPASS_EN
            // A same-cycle reservation of the read register suppresses forwarding.
            assign w_fwd = w_wr_ok && !rst && (wR == w_ra[p]) &&
                           !(rsv_en && (rsv_addr == w_ra[p]));
`else
            assign w_fwd = 1'b0;
`endif
            assign w_rd[p] = (w_zero || rst) ? '0 : (w_fwd ? wD : r_data[w_ra[p]]);
            assign w_rb[p] = (w_zero || rst || w_fwd) ? 1'b0 : r_busy[w_ra[p]];
        end
    endgenerate

    assign rD1      = w_rd[0];
    assign rD2      = w_rd[1];
    assign rbusy1   = w_rb[0];
    assign rbusy2   = w_rb[1];
    assign stall    = (w_rb[0] & re1) | (w_rb[1] & re2);
    assign pend_cnt = r_pend_cnt;

endmodule

`default_nettype wire
